// File: rtl/axis_boxcar_decimator.sv
// axis_boxcar_decimator: averages 2^L valid samples into one single-cycle output strobe.
module axis_boxcar_decimator #(
  parameter int inout_width           = 32,
  parameter int max_log2_n            = 16,
  parameter int default_log2_n        = 0,
  parameter int configuration_address = 999
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic [31:0]            config_addr,
  input  logic [511:0]           config_data,
  input  logic [inout_width-1:0] S_AXIS_tdata,
  input  logic                   S_AXIS_tvalid,
  output logic [inout_width-1:0] M_AXIS_tdata,
  output logic                   M_AXIS_tvalid
);
  localparam int acc_w = inout_width + max_log2_n;
  localparam int cnt_w = max_log2_n + 1;
  localparam int l_w   = $clog2(max_log2_n + 1);
  logic signed [acc_w-1:0] acc, sum, rsum, avg;
  logic [cnt_w-1:0] count, cnt_max;
  logic [l_w-1:0] log2n, cfg_l;
  logic [4:0] cfg_raw;
  logic round_en, hit, last;
  // Restart is simply "address matches this cycle"; accumulation resumes on the first non-matching cycle.
  always_comb begin
    hit     = config_addr == 32'(configuration_address);
    cfg_raw = config_data[4:0];
    cfg_l   = int'(cfg_raw) > max_log2_n ? l_w'(max_log2_n) : l_w'(cfg_raw);
    cnt_max = (cnt_w'(1) << log2n) - cnt_w'(1);
    last    = count == cnt_max;
    sum     = acc + acc_w'($signed(S_AXIS_tdata));
    rsum    = sum + (acc_w'(round_en && log2n != '0) << (log2n - l_w'(1)));
    avg     = rsum >>> log2n;
  end
  wire unused = ^{config_data[511:33], config_data[31:5], avg[acc_w-1:inout_width]};
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      count         <= '0;
      M_AXIS_tdata  <= '0;
      M_AXIS_tvalid <= 1'b0;
      log2n         <= l_w'(default_log2_n);
      round_en      <= 1'b1;
    end else if (hit) begin
      log2n         <= cfg_l;
      round_en      <= config_data[32];
      acc           <= '0;
      count         <= '0;
      M_AXIS_tvalid <= 1'b0;
    end else begin
      M_AXIS_tvalid <= S_AXIS_tvalid && last;
      if (S_AXIS_tvalid) begin
        acc   <= last ? '0 : sum;
        count <= last ? '0 : count + cnt_w'(1);
        if (last) M_AXIS_tdata <= avg[inout_width-1:0];
      end
    end
  end
endmodule
